// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, word-length decode, oversampling
// defaults and the parity helper used by both TX and RX paths.
package uart_pkg;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int TICK_W         = $clog2(OVERSAMPLE_DEF);

   localparam logic [1:0] WLS_5 = 2'd0;
   localparam logic [1:0] WLS_6 = 2'd1;
   localparam logic [1:0] WLS_7 = 2'd2;
   localparam logic [1:0] WLS_8 = 2'd3;

   typedef logic [2:0] uart_state_t;
   localparam uart_state_t S_IDLE   = 3'd0;
   localparam uart_state_t S_START  = 3'd1;
   localparam uart_state_t S_DATA   = 3'd2;
   localparam uart_state_t S_PARITY = 3'd3;
   localparam uart_state_t S_STOP   = 3'd4;

   function automatic logic [7:0] wls_mask(input logic [1:0] wls);
      logic [7:0] m;
      case (wls)
         WLS_5:   m = 8'h1F;
         WLS_6:   m = 8'h3F;
         WLS_7:   m = 8'h7F;
         WLS_8:   m = 8'hFF;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   // eps=1 gives even parity (plain XOR), eps=0 odd; bits above the word length never count
   function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] wls,
                                        input logic eps);
      return (^(data & wls_mask(wls))) ^ ~eps;
   endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// FIFO-side and line-side signals of the UART transmit serializer.
// slave = serializer, master = whatever drives the LCR/FIFO/tick inputs.
interface uart_tx_serializer_if;
   logic       tx_en;
   logic       baud_tick;
   logic [1:0] lcr_wls;
   logic       lcr_stb;
   logic       lcr_pen;
   logic       lcr_eps;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_rd;
   logic       txd;
   logic       tx_busy;
   logic       tx_done;

   modport master (
      output tx_en, baud_tick, lcr_wls, lcr_stb, lcr_pen, lcr_eps, fifo_empty, fifo_data,
      input  fifo_rd, txd, tx_busy, tx_done
   );

   modport slave (
      input  tx_en, baud_tick, lcr_wls, lcr_stb, lcr_pen, lcr_eps, fifo_empty, fifo_data,
      output fifo_rd, txd, tx_busy, tx_done
   );
endinterface

// File: rtl/uart_parity_gen.sv
// Combinational parity over the active data bits; shared by the TX and RX paths.
module uart_parity_gen
   import uart_pkg::*;
(
   input  logic [7:0] data_i,
   input  logic [1:0] wls_i,
   input  logic       eps_i,
   output logic       parity_o
);

   // parity is a pure function of the byte and the latched line settings
   always_comb begin
      parity_o = calc_parity(data_i, wls_i, eps_i);
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops the TX FIFO head and frames it start/data/parity/stop.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic               pclk,
   input  logic               presetn,
   uart_tx_serializer_if.slave bus
);

   localparam int            TW        = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

   uart_state_t   state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [1:0]    wls_q, wls_d;
   logic          stb_q, stb_d;
   logic          pen_q, pen_d;
   logic          par_q, par_d;
   logic          txd_q, txd_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pop_s;
   logic          bit_end_s;
   logic          pen_s;
   logic          par_s;

`ifdef UART_TX_PARITY_EN
   uart_parity_gen u_par (
      .data_i   (bus.fifo_data),
      .wls_i    (bus.lcr_wls),
      .eps_i    (bus.lcr_eps),
      .parity_o (par_s)
   );
   assign pen_s = bus.lcr_pen;
`else
   logic unused_lcr_s;
   assign unused_lcr_s = bus.lcr_pen ^ bus.lcr_eps;
   assign par_s        = 1'b0;
   assign pen_s        = 1'b0;
`endif

   // Holding off during the tx_done cycle puts the next pop one cycle after tx_done.
   assign pop_s     = (state_q == S_IDLE) & bus.tx_en & ~bus.fifo_empty & ~done_q;
   assign bit_end_s = bus.baud_tick & (tick_q == TICK_LAST);

   // Next-state logic for the framing FSM, counters and shift register
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      wls_d   = wls_q;
      stb_d   = stb_q;
      pen_d   = pen_q;
      par_d   = par_q;
      txd_d   = txd_q;
      done_d  = 1'b0;
      if (state_q == S_IDLE) begin
         if (pop_s) begin
            shift_d = bus.fifo_data;
            wls_d   = bus.lcr_wls;
            stb_d   = bus.lcr_stb;
            pen_d   = pen_s;
            par_d   = par_s;
            tick_d  = '0;
            bit_d   = 3'd0;
            state_d = S_START;
            txd_d   = 1'b0;
         end else begin
            txd_d = 1'b1;
         end
      end else if (bus.baud_tick) begin
         if (bit_end_s) begin
            tick_d = '0;
            case (state_q)
               S_START: begin
                  state_d = S_DATA;
                  bit_d   = 3'd0;
                  txd_d   = shift_q[0];
               end
               S_DATA: begin
                  if (bit_q == (3'd4 + {1'b0, wls_q})) begin
                     bit_d = 3'd0;
                     if (pen_q) begin
                        state_d = S_PARITY;
                        txd_d   = par_q;
                     end else begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                     end
                  end else begin
                     bit_d   = bit_q + 3'd1;
                     shift_d = {1'b0, shift_q[7:1]};
                     txd_d   = shift_q[1];
                  end
               end
               S_PARITY: begin
                  state_d = S_STOP;
                  bit_d   = 3'd0;
                  txd_d   = 1'b1;
               end
               S_STOP: begin
                  txd_d = 1'b1;
                  if (stb_q && (bit_q == 3'd0)) begin
                     bit_d = 3'd1;
                  end else begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end
               default: begin
                  state_d = S_IDLE;
                  txd_d   = 1'b1;
               end
            endcase
         end else begin
            tick_d = tick_q + TW'(1);
         end
      end else begin
         tick_d = tick_q;
      end
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset aborts any frame and forces the line high
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         wls_q   <= 2'd0;
         stb_q   <= 1'b0;
         pen_q   <= 1'b0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         wls_q   <= wls_d;
         stb_q   <= stb_d;
         pen_q   <= pen_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.fifo_rd = pop_s;
   assign bus.txd     = txd_q;
   assign bus.tx_busy = busy_q;
   assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: a FIFO model feeds bytes, expected frames are
// queued at each pop, and a line monitor checks every baud tick of each frame.
module tb_uart_tx_serializer;
   import uart_pkg::*;

   logic pclk    = 1'b0;
   logic presetn = 1'b0;

   uart_tx_serializer_if bus();

   uart_tx_serializer dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic [11:0] bits;
      int          len;
   } frame_t;

   frame_t     sb[$];
   logic [7:0] fifo_q[$];
   int         errors = 0;
   int         checks = 0;
   int         pops   = 0;
   int         dones  = 0;
   int         cyc_n  = 0;
   bit         rd_flag = 1'b0;
   bit         lcr_jitter = 1'b0;
   bit         in_frame = 1'b0;
   bit         bad = 1'b0;
   bit         done_pending = 1'b0;
   bit         post_done = 1'b0;
   frame_t     cur;
   int         n = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference frame from the line rules: start 0, LSB-first data, optional parity, stop 1s
   function automatic frame_t model_frame(input logic [7:0] d, input logic [1:0] wls,
                                          input logic stb, input logic pen, input logic eps);
      frame_t f;
      int     nd;
      int     ones;
      f.bits = '0;
      nd     = 5 + int'(wls);
      ones   = 0;
      f.bits[0] = 1'b0;
      f.len  = 1;
      for (int i = 0; i < nd; i++) begin
         f.bits[f.len] = d[i];
         ones += int'(d[i]);
         f.len++;
      end
      if (pen) begin
         f.bits[f.len] = eps ? ones[0] : ~ones[0];
         f.len++;
      end
      f.bits[f.len] = 1'b1;
      f.len++;
      if (stb) begin
         f.bits[f.len] = 1'b1;
         f.len++;
      end
      return f;
   endfunction

   function automatic logic par_enabled();
`ifdef UART_TX_PARITY_EN
      return bus.lcr_pen;
`else
      return 1'b0;
`endif
   endfunction

   function automatic void refresh_fifo();
      bus.fifo_empty = (fifo_q.size() == 0);
      bus.fifo_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
   endfunction

   task automatic cyc();
      @(posedge pclk);
      #1;
      if (rd_flag) begin
         fifo_q.delete(0);
         rd_flag = 1'b0;
      end
      cyc_n++;
      bus.baud_tick = (cyc_n % 4 == 0);
      if (lcr_jitter && ($urandom_range(0, 49) == 0)) begin
         bus.lcr_wls = 2'($urandom_range(0, 3));
         bus.lcr_stb = 1'($urandom_range(0, 1));
         bus.lcr_pen = 1'($urandom_range(0, 1));
         bus.lcr_eps = 1'($urandom_range(0, 1));
      end
      refresh_fifo();
   endtask

   task automatic set_lcr(input logic [1:0] wls, input logic stb, input logic pen, input logic eps);
      bus.lcr_wls = wls;
      bus.lcr_stb = stb;
      bus.lcr_pen = pen;
      bus.lcr_eps = eps;
   endtask

   task automatic push_byte(input logic [7:0] d);
      fifo_q.push_back(d);
      refresh_fifo();
   endtask

   task automatic wait_idle(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         cyc();
         if (!bus.tx_busy && !in_frame && !done_pending && !post_done && !rd_flag &&
             (fifo_q.size() == 0 || !bus.tx_en))
            break;
      end
      if (i >= budget) check("idle_timeout", 32'(i), 32'(budget - 1));
   endtask

   // Monitor: decode the line tick by tick against the head of the scoreboard
   always @(negedge pclk) begin
      if (!presetn) begin
         in_frame     = 1'b0;
         done_pending = 1'b0;
         post_done    = 1'b0;
         rd_flag      = 1'b0;
         sb.delete();
      end else begin
         if (post_done) begin
            post_done = 1'b0;
            check("pop_after_done", 32'(bus.fifo_rd),
                  32'(bus.tx_en && fifo_q.size() > 0));
         end
         if (done_pending) begin
            done_pending = 1'b0;
            post_done    = 1'b1;
            dones++;
            check("tx_done", 32'(bus.tx_done), 32'd1);
            check("pop_gap", 32'(bus.fifo_rd), 32'd0);
            check("idle_after_frame", 32'({bus.txd, bus.tx_busy}), 32'h2);
         end else if (bus.tx_done) begin
            check("spurious_done", 32'(bus.tx_done), 32'd0);
         end
         if (!in_frame && bus.txd == 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL start_bit: txd=0 with no frame queued, expected 1");
            end else begin
               cur      = sb.pop_front();
               in_frame = 1'b1;
               n        = 0;
               bad      = 1'b0;
            end
         end
         if (in_frame && bus.baud_tick) begin
            if (bus.txd !== cur.bits[n / 16] || bus.tx_busy !== 1'b1) begin
               if (!bad)
                  $display("FAIL line_bit: bit %0d txd=%0b busy=%0b expected txd=%0b busy=1",
                           n / 16, bus.txd, bus.tx_busy, cur.bits[n / 16]);
               bad = 1'b1;
            end
            n++;
            if (n == 16 * cur.len) begin
               in_frame     = 1'b0;
               done_pending = 1'b1;
               check("frame_bits_ok", 32'(bad), 32'd0);
            end
         end
         if (bus.fifo_rd) begin
            pops++;
            checks++;
            if (fifo_q.size() == 0) begin
               errors++;
               $display("FAIL rd_when_empty: fifo_rd=1 expected 0");
            end else begin
               sb.push_back(model_frame(fifo_q[0], bus.lcr_wls, bus.lcr_stb,
                                        par_enabled(), bus.lcr_eps));
               rd_flag = 1'b1;
            end
         end
      end
   end

   initial begin
      int p0;
      bus.tx_en      = 1'b0;
      bus.baud_tick  = 1'b0;
      set_lcr(2'd3, 1'b0, 1'b0, 1'b0);
      refresh_fifo();

      // reset and idle line
      presetn = 1'b0;
      repeat (3) cyc();
      check("rst_outputs", 32'({bus.txd, bus.tx_busy, bus.tx_done, bus.fifo_rd}), 32'h8);
      presetn = 1'b1;
      bus.tx_en = 1'b1;
      repeat (200) cyc();
      check("idle_txd_busy", 32'({bus.txd, bus.tx_busy}), 32'h2);
      check("idle_no_pop", 32'(pops), 32'd0);

      // 8N1 0xA5
      push_byte(8'hA5);
      wait_idle(4000);
      check("a5_pops", 32'(pops), 32'd1);
      check("a5_dones", 32'(dones), 32'd1);

      // 7E2 0x41 and 5O1 0xFF (parity present only with the macro)
      set_lcr(2'd2, 1'b1, 1'b1, 1'b1);
      push_byte(8'h41);
      wait_idle(4000);
      set_lcr(2'd0, 1'b0, 1'b1, 1'b0);
      push_byte(8'hFF);
      wait_idle(4000);
      check("directed_dones", 32'(dones), 32'd3);

      // back-to-back, tx_en dropped during frame 2
      set_lcr(2'd3, 1'b0, 1'b0, 1'b0);
      bus.tx_en = 1'b0;
      push_byte(8'h12);
      push_byte(8'h34);
      push_byte(8'h56);
      p0 = pops;
      bus.tx_en = 1'b1;
      for (int i = 0; i < 3000 && pops < p0 + 2; i++) cyc();
      check("b2b_second_pop", 32'(pops - p0), 32'd2);
      repeat (100) cyc();
      bus.tx_en = 1'b0;
      wait_idle(4000);
      repeat (50) cyc();
      check("b2b_stop_pops", 32'(pops - p0), 32'd2);
      check("b2b_left_in_fifo", 32'(fifo_q.size()), 32'd1);
      bus.tx_en = 1'b1;
      wait_idle(4000);
      check("b2b_total_pops", 32'(pops - p0), 32'd3);

      // reset during data bit 3, then a fresh frame from the remaining byte
      push_byte(8'h3C);
      push_byte(8'hC3);
      for (int i = 0; i < 1000 && !(in_frame && n >= 16 * 4 + 8); i++) cyc();
      check("reached_data_bit3", 32'(in_frame && n >= 16 * 4 + 8), 32'd1);
      presetn = 1'b0;
      #1;
      check("async_rst_line", 32'({bus.txd, bus.tx_busy}), 32'h2);
      repeat (3) cyc();
      p0 = pops;
      presetn = 1'b1;
      wait_idle(4000);
      check("post_rst_pop", 32'(pops - p0), 32'd1);
      check("post_rst_fifo", 32'(fifo_q.size()), 32'd0);

      // random bytes and line settings, settings jittering mid-frame
      lcr_jitter = 1'b1;
      for (int k = 0; k < 20; k++) begin
         set_lcr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         push_byte(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 2) == 0) push_byte(8'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 20)) cyc();
         wait_idle(4000);
      end
      lcr_jitter = 1'b0;
      check("final_sb_empty", 32'(sb.size()), 32'd0);
      check("final_pops_done", 32'(pops - dones), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit serializer directly downstream of the 16-entry UART TX FIFO.
- Pops one byte from the FIFO's show-ahead read port and frames it as start / data / optional parity / stop bits on the serial line.
- Bit timing comes from a shared 16x baud tick enable; runs entirely in the pclk domain.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per serial bit; must be a power of two, at least 4.

Ports:
- pclk  input  1  system clock; all logic on the rising edge.
- presetn  input  1  asynchronous active-low reset.
- tx_en  input  1  transmitter enable; sampled only in IDLE.
- baud_tick  input  1  single-cycle enable at 16x the baud rate.
- lcr_wls  input  2  word length select; data bits = 5 + lcr_wls.
- lcr_stb  input  1  0 = one stop bit, 1 = two stop bits.
- lcr_pen  input  1  parity enable; ignored unless UART_TX_PARITY_EN is defined.
- lcr_eps  input  1  1 = even parity, 0 = odd parity; same macro condition as lcr_pen.
- fifo_empty  input  1  TX FIFO empty flag.
- fifo_data  input  8  TX FIFO head entry; valid whenever fifo_empty=0.
- fifo_rd  output  1  pop strobe to the FIFO, one cycle wide.
- txd  output  1  serial output, idles high.
- tx_busy  output  1  high whenever state is not IDLE.
- tx_done  output  1  one-cycle pulse at the end of a frame's last stop bit.

Behaviour:
- Reset (async, presetn=0): state=IDLE, txd=1, tx_busy=0, tx_done=0, fifo_rd=0, tick and bit counters=0, shift register=0. Reset mid-frame aborts the frame; txd returns high immediately.
- fifo_rd is combinational: (state==IDLE) & tx_en & ~fifo_empty. It is never asserted when fifo_empty=1.
- In that same cycle:
  - shift register <= fifo_data;
  - lcr_wls, lcr_stb, lcr_pen and lcr_eps are latched for the whole frame;
  - tick counter is cleared;
  - state <= START.
- txd is registered. It drives 0 from the first cycle in START.
- Bit duration: the tick counter increments on each baud_tick. A bit ends on the baud_tick where the counter equals OVERSAMPLE-1; the counter then wraps to 0. Cycles without baud_tick hold all state.
- State transitions:
  - START: txd=0 for one bit -> DATA.
  - DATA: LSB first, shift right one bit per bit period. After bit (4 + wls) -> PARITY if parity is enabled for this frame, else STOP.
  - PARITY: txd = XOR of the active data bits when eps=1 (even); inverted when eps=0 (odd). Bits above the word length are excluded. -> STOP.
  - STOP: txd=1 for 1 or 2 bits per the latched stb. At the end: tx_done=1 for one cycle, state <= IDLE.
- Back-to-back frames: the earliest next pop is the cycle after returning to IDLE. The gap is therefore 1 pclk cycle, not a bit time.
- tx_en deasserted mid-frame: the current frame completes; no further pop.
- LCR changes mid-frame have no effect until the next pop.
- Frame length in bit periods = 1 + (5 + wls) + parity + (1 or 2); minimum 7, maximum 12.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: lcr_pen and lcr_eps are honoured and the PARITY state exists.
- Undefined: the ports remain in the interface but are ignored, PARITY is unreachable and optimised away, and frames never carry a parity bit.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - localparams for word-length decode (WLS_5..WLS_8);
  - OVERSAMPLE default and tick counter width (clog2).
- Optional sub-module uart_parity_gen: combinational parity from data[7:0], wls and eps; reused by the RX path.
- Counters, shift register and FSM stay in uart_tx_serializer.

Test Plan:
- Reset idle: presetn low then high, FIFO empty, baud_tick every 4 cycles -> txd=1, fifo_rd never asserted, tx_busy=0.
- 8N1 byte: fifo_data=0xA5, wls=3, stb=0, pen=0 -> one fifo_rd pulse; txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks; tx_done after 160 ticks.
- 7E2 with macro: data=0x41, wls=2, pen=1, eps=1 -> data bits 1,0,0,0,0,0,1; parity bit 0; two stop bits; frame = 11 bit periods.
- 5O1 with macro: data=0xFF, wls=0, pen=1, eps=0 -> five 1s then parity 0; bits 5-7 excluded from both the payload and the parity calculation.
- Back-to-back: three bytes queued, tx_en=1 -> exactly 3 fifo_rd pulses, each 1 cycle after the preceding tx_done. Drop tx_en mid-frame 2 -> frame 2 completes, frame 3 is not popped.
- Reset mid-frame: assert presetn during DATA bit 3 -> txd=1 and tx_busy=0 asynchronously. After release with the FIFO non-empty, a fresh frame starts with a pop.
